// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, PRId and handler vector.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package cp0_pkg;

  // Register addresses seen by mtc0/mfc0
  localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ADDR_SR       = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;
  localparam logic [4:0] CP0_ADDR_PRID     = 5'd15;

  // ExcCode values (0 doubles as "no exception pending" on exc_code_m)
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] CP0_PRID_VAL     = 32'h0000_2020;
  localparam logic [31:0] CP0_HANDLER_ADDR = 32'h0000_4180;

  // Processor mode; encoding matches SR.EXL so the state can be read back directly
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

  // EPC always holds a word-aligned address
  function automatic logic [31:0] epc_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_irq_pri.sv
// Interrupt/exception detection and priority: interrupts beat exceptions, EXL masks both.
// Latency: purely combinational, result valid in the same cycle.
// Backpressure: none; the pipeline must honour int_req immediately.
module cp0_irq_pri
  import cp0_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code_m,
  output logic       irq,
  output logic       exc,
  output logic       int_req,
  output logic [4:0] exc_code_sel
);

  // Detect pending events and pick the ExcCode to latch
  always_comb begin
    irq          = ie & ~exl & (|(hw_int & im));
    exc          = (exc_code_m != EXC_INT) & ~exl;
    int_req      = irq | exc;
    exc_code_sel = irq ? EXC_INT : exc_code_m;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, RUN/HANDLER mode FSM, mtc0/mfc0 access.
// Latency: int_req, e_jump and rdata are same-cycle; register updates land on the next edge.
// Backpressure: none. Optional BadVAddr register enabled by defining CP0_BADVADDR_EN.
module cp0_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  input  logic        eret_m,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] badvaddr_m,
`endif
  output logic [31:0] rdata,
  output logic        int_req,
  output logic        e_jump,
  output logic [31:0] epc
);

  cp0_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
`endif

  logic        exl;
  logic        irq, exc;
  logic [4:0]  exc_code_sel;
  logic [31:0] sr_val, cause_val;

  assign exl = (state_q == ST_HANDLER);

  cp0_irq_pri u_irq_pri (
    .ie           (ie_q),
    .exl          (exl),
    .im           (im_q),
    .hw_int       (hw_int),
    .exc_code_m   (exc_code_m),
    .irq          (irq),
    .exc          (exc),
    .int_req      (int_req),
    .exc_code_sel (exc_code_sel)
  );

  assign e_jump = eret_m & ~int_req;
  assign epc    = epc_q;

  assign sr_val    = {16'h0, im_q, 8'h0, exl, ie_q};
  assign cause_val = {bd_q, 15'h0, ip_q, 3'h0, exccode_q, 2'b00};

  // mfc0 read mux; no forwarding of a same-cycle mtc0
  always_comb begin
    rdata = 32'h0;
    case (cp0_addr)
      CP0_ADDR_SR:       rdata = sr_val;
      CP0_ADDR_CAUSE:    rdata = cause_val;
      CP0_ADDR_EPC:      rdata = epc_q;
      CP0_ADDR_PRID:     rdata = CP0_PRID_VAL;
`ifdef CP0_BADVADDR_EN
      CP0_ADDR_BADVADDR: rdata = badvaddr_q;
`endif
      default:           rdata = 32'h0;
    endcase
  end

  // Next-state: exception entry beats eret, which beats a plain mtc0 write
  always_comb begin
    state_d   = state_q;
    im_d      = im_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ip_d      = hw_int;
    exccode_d = exccode_q;
    epc_d     = epc_q;
`ifdef CP0_BADVADDR_EN
    badvaddr_d = badvaddr_q;
`endif
    if (int_req) begin
      state_d   = ST_HANDLER;
      bd_d      = bd_m;
      exccode_d = exc_code_sel;
      epc_d     = epc_align(bd_m ? (pc_m - 32'd4) : pc_m);
`ifdef CP0_BADVADDR_EN
      if (exc_code_sel == EXC_ADEL || exc_code_sel == EXC_ADES) begin
        badvaddr_d = badvaddr_m;
      end
`endif
    end else begin
      if (mtc0_we) begin
        case (cp0_addr)
          CP0_ADDR_SR: begin
            im_d    = wdata[15:10];
            state_d = cp0_state_e'(wdata[1]);
            ie_d    = wdata[0];
          end
          CP0_ADDR_EPC: epc_d = epc_align(wdata);
          default: ;
        endcase
      end
      if (eret_m) begin
        state_d = ST_RUN;
      end
    end
  end

  // Mode FSM and CP0 register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      im_q      <= 6'h0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'h0;
      exccode_q <= 5'h0;
      epc_q     <= 32'h0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      im_q      <= im_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl (default build, BadVAddr disabled).
// Inputs change 1ns after the rising edge; outputs are read mid-cycle.
// Expected values are hand-computed constants.
module tb_cp0_ctrl;
  import cp0_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic        eret_m;
  logic [31:0] rdata;
  logic        int_req;
  logic        e_jump;
  logic [31:0] epc;

  int pass_cnt;
  int total_cnt;

  cp0_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .hw_int     (hw_int),
    .mtc0_we    (mtc0_we),
    .cp0_addr   (cp0_addr),
    .wdata      (wdata),
    .eret_m     (eret_m),
    .rdata      (rdata),
    .int_req    (int_req),
    .e_jump     (e_jump),
    .epc        (epc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = rdata;
  endtask

  task automatic idle();
    pc_m = 32'h0; bd_m = 1'b0; exc_code_m = 5'd0; hw_int = 6'd0;
    mtc0_we = 1'b0; cp0_addr = 5'd0; wdata = 32'h0; eret_m = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; cp0_addr = a; wdata = d;
    cyc();
    mtc0_we = 1'b0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle();
    reset_n = 1'b0;
    #3;
    rd(CP0_ADDR_SR, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_sr got %h want %h", v, 32'h0); else pass_cnt++;
    rd(CP0_ADDR_CAUSE, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_cause got %h want %h", v, 32'h0); else pass_cnt++;
    rd(CP0_ADDR_PRID, v);
    total_cnt++; if (v !== 32'h0000_2020) $display("FAIL reset_prid got %h want %h", v, 32'h0000_2020); else pass_cnt++;
    total_cnt++; if (epc !== 32'h0) $display("FAIL reset_epc got %h want %h", epc, 32'h0); else pass_cnt++;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b want 0", int_req); else pass_cnt++;
    exc_code_m = EXC_RI;
    #1;
    total_cnt++; if (int_req !== 1'b1) $display("FAIL reset_exc_int_req got %b want 1", int_req); else pass_cnt++;
    exc_code_m = 5'd0; eret_m = 1'b1;
    #1;
    total_cnt++; if (e_jump !== 1'b1) $display("FAIL reset_e_jump got %b want 1", e_jump); else pass_cnt++;
    eret_m = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // SR=0x401, hw_int[0] -> same-cycle int_req, then EPC/EXL/Cause latched
  task automatic test_irq();
    logic [31:0] v;
    mtc0(CP0_ADDR_SR, 32'h0000_0401);
    rd(CP0_ADDR_SR, v);
    total_cnt++; if (v !== 32'h0000_0401) $display("FAIL irq_sr_write got %h want %h", v, 32'h0000_0401); else pass_cnt++;
    hw_int = 6'b000001; pc_m = 32'h0000_3010;
    #1;
    total_cnt++; if (int_req !== 1'b1) $display("FAIL irq_int_req got %b want 1", int_req); else pass_cnt++;
    cyc();
    hw_int = 6'd0; pc_m = 32'h0;
    rd(CP0_ADDR_EPC, v);
    total_cnt++; if (v !== 32'h0000_3010) $display("FAIL irq_epc got %h want %h", v, 32'h0000_3010); else pass_cnt++;
    rd(CP0_ADDR_SR, v);
    total_cnt++; if (v !== 32'h0000_0403) $display("FAIL irq_sr_exl got %h want %h", v, 32'h0000_0403); else pass_cnt++;
    rd(CP0_ADDR_CAUSE, v);
    total_cnt++; if (v !== 32'h0000_0400) $display("FAIL irq_cause got %h want %h", v, 32'h0000_0400); else pass_cnt++;
    cyc();
  endtask

  // EXL=1 masks both exceptions and interrupts
  task automatic test_exl_suppress();
    logic [31:0] v;
    exc_code_m = EXC_OV; hw_int = 6'b000001; pc_m = 32'h0000_3050;
    #1;
    total_cnt++; if (int_req !== 1'b0) $display("FAIL exl_int_req got %b want 0", int_req); else pass_cnt++;
    cyc();
    exc_code_m = 5'd0; hw_int = 6'd0; pc_m = 32'h0;
    rd(CP0_ADDR_EPC, v);
    total_cnt++; if (v !== 32'h0000_3010) $display("FAIL exl_epc_kept got %h want %h", v, 32'h0000_3010); else pass_cnt++;
    cyc();
  endtask

  task automatic test_eret();
    logic [31:0] v;
    eret_m = 1'b1;
    #1;
    total_cnt++; if (e_jump !== 1'b1) $display("FAIL eret_e_jump got %b want 1", e_jump); else pass_cnt++;
    total_cnt++; if (epc !== 32'h0000_3010) $display("FAIL eret_epc got %h want %h", epc, 32'h0000_3010); else pass_cnt++;
    cyc();
    eret_m = 1'b0;
    rd(CP0_ADDR_SR, v);
    total_cnt++; if (v !== 32'h0000_0401) $display("FAIL eret_exl_clear got %h want %h", v, 32'h0000_0401); else pass_cnt++;
    cyc();
  endtask

  // Exception in a delay slot: EPC backs up to the branch
  task automatic test_exc();
    logic [31:0] v;
    exc_code_m = EXC_RI; bd_m = 1'b1; pc_m = 32'h0000_3024;
    #1;
    total_cnt++; if (int_req !== 1'b1) $display("FAIL exc_int_req got %b want 1", int_req); else pass_cnt++;
    cyc();
    exc_code_m = 5'd0; bd_m = 1'b0; pc_m = 32'h0;
    rd(CP0_ADDR_EPC, v);
    total_cnt++; if (v !== 32'h0000_3020) $display("FAIL exc_epc got %h want %h", v, 32'h0000_3020); else pass_cnt++;
    rd(CP0_ADDR_CAUSE, v);
    total_cnt++; if (v !== 32'h8000_0028) $display("FAIL exc_cause got %h want %h", v, 32'h8000_0028); else pass_cnt++;
    cyc();
  endtask

  task automatic test_mtc0();
    logic [31:0] v;
    mtc0(CP0_ADDR_CAUSE, 32'hFFFF_FFFF);
    rd(CP0_ADDR_CAUSE, v);
    total_cnt++; if (v !== 32'h8000_0028) $display("FAIL mtc0_cause_ignored got %h want %h", v, 32'h8000_0028); else pass_cnt++;
    mtc0(CP0_ADDR_PRID, 32'h0);
    rd(CP0_ADDR_PRID, v);
    total_cnt++; if (v !== 32'h0000_2020) $display("FAIL mtc0_prid_ignored got %h want %h", v, 32'h0000_2020); else pass_cnt++;
    mtc0_we = 1'b1; cp0_addr = CP0_ADDR_EPC; wdata = 32'h0000_3007;
    #1;
    total_cnt++; if (rdata !== 32'h0000_3020) $display("FAIL mtc0_no_forward got %h want %h", rdata, 32'h0000_3020); else pass_cnt++;
    cyc();
    mtc0_we = 1'b0; wdata = 32'h0;
    rd(CP0_ADDR_EPC, v);
    total_cnt++; if (v !== 32'h0000_3004) $display("FAIL mtc0_epc_align got %h want %h", v, 32'h0000_3004); else pass_cnt++;
    rd(5'd8, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL unimpl_addr8 got %h want %h", v, 32'h0); else pass_cnt++;
    rd(5'd3, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL unimpl_addr3 got %h want %h", v, 32'h0); else pass_cnt++;
    cyc();
  endtask

  // eret colliding with an interrupt: the interrupt wins
  task automatic test_eret_irq();
    logic [31:0] v;
    mtc0(CP0_ADDR_SR, 32'h0000_0401);
    eret_m = 1'b1; hw_int = 6'b000001; pc_m = 32'h0000_3040;
    #1;
    total_cnt++; if (int_req !== 1'b1) $display("FAIL eret_irq_int_req got %b want 1", int_req); else pass_cnt++;
    total_cnt++; if (e_jump !== 1'b0) $display("FAIL eret_irq_e_jump got %b want 0", e_jump); else pass_cnt++;
    cyc();
    eret_m = 1'b0; hw_int = 6'd0; pc_m = 32'h0;
    rd(CP0_ADDR_SR, v);
    total_cnt++; if (v !== 32'h0000_0403) $display("FAIL eret_irq_exl got %h want %h", v, 32'h0000_0403); else pass_cnt++;
    rd(CP0_ADDR_EPC, v);
    total_cnt++; if (v !== 32'h0000_3040) $display("FAIL eret_irq_epc got %h want %h", v, 32'h0000_3040); else pass_cnt++;
    eret_m = 1'b1;
    cyc();
    eret_m = 1'b0;
    cyc();
  endtask

  // mtc0 in an int_req cycle is dropped
  task automatic test_mtc0_blocked();
    logic [31:0] v;
    hw_int = 6'b000001; pc_m = 32'h0000_3100;
    mtc0_we = 1'b1; cp0_addr = CP0_ADDR_EPC; wdata = 32'h0000_5000;
    cyc();
    mtc0_we = 1'b0; wdata = 32'h0; hw_int = 6'd0; pc_m = 32'h0;
    rd(CP0_ADDR_EPC, v);
    total_cnt++; if (v !== 32'h0000_3100) $display("FAIL mtc0_blocked_epc got %h want %h", v, 32'h0000_3100); else pass_cnt++;
    cyc();
  endtask

  // Reset while in HANDLER: back to RUN, EPC discarded, immediately
  task automatic test_reset_handler();
    logic [31:0] v;
    reset_n = 1'b0;
    rd(CP0_ADDR_SR, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL rst_handler_sr got %h want %h", v, 32'h0); else pass_cnt++;
    total_cnt++; if (epc !== 32'h0) $display("FAIL rst_handler_epc got %h want %h", epc, 32'h0); else pass_cnt++;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset_n = 1'b1;
    idle();
    #2;
    test_reset();
    test_irq();
    test_exl_suppress();
    test_eret();
    test_exc();
    test_mtc0();
    test_eret_irq();
    test_mtc0_blocked();
    test_reset_handler();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: pc_m  in  32  PC of the instruction in the M stage.
REQ-004 SHALL provide: bd_m  in  1  M-stage instruction sits in a branch delay slot.
REQ-005 SHALL provide: exc_code_m  in  5  pending exception code of the M-stage instruction; 0 means none.
REQ-006 SHALL provide: hw_int  in  6  level-sensitive hardware interrupt lines.
REQ-007 SHALL provide: mtc0_we, cp0_addr[4:0], wdata[31:0]  in  mtc0 write port.
REQ-008 SHALL provide: eret_m  in  1  eret is in the M stage.
REQ-009 SHALL provide: rdata  out  32  combinational mfc0 read of cp0_addr; unimplemented addresses read 0.
REQ-010 SHALL provide: int_req  out  1  redirect to handler 32'h0000_4180; drives the NPC IntReq input.
REQ-011 SHALL provide: e_jump  out  1  return to epc; drives the NPC eJump input.
REQ-012 SHALL provide: epc  out  32  current EPC register value.

Function
REQ-013 SHALL implement SR(12): IM[15:10], EXL[1], IE[0], other bits 0; Cause(13): BD[31], IP[15:10], ExcCode[6:2], other bits 0; EPC(14); PRId(15), constant 32'h0000_2020.
REQ-014 SHALL run a 2-state FSM: RUN (EXL=0) and HANDLER (EXL=1); RUN->HANDLER on int_req; HANDLER->RUN on eret_m without int_req; the state is SR.EXL.
REQ-015 SHALL compute irq = IE & !EXL & |(hw_int & IM) and exc = (exc_code_m != 0) & !EXL.
REQ-016 SHALL drive int_req = irq | exc combinationally in the same cycle; no extra latency.
REQ-017 SHALL give interrupts priority over exceptions: latch ExcCode=0 on irq, else exc_code_m.
REQ-018 SHALL, on the int_req edge, set EXL=1, latch Cause.BD=bd_m, and latch EPC = (bd_m ? pc_m-4 : pc_m) with bits [1:0] forced to 00.
REQ-019 SHALL sample Cause.IP <= hw_int every cycle, unconditionally.
REQ-020 SHALL assert e_jump = eret_m & !int_req; EXL clears on the following edge.
REQ-021 SHALL, when eret_m and int_req coincide, let int_req win: EXL stays 1 and EPC is reloaded.
REQ-022 SHALL, in the same cycle as int_req, suppress mtc0 writes.
REQ-023 SHALL make mtc0 able to write SR (IM/EXL/IE only) and EPC (bits [1:0] forced to 00).
REQ-024 SHALL ignore mtc0 writes to Cause and PRId.
REQ-025 SHALL not forward rdata: an mtc0 takes effect on the next cycle.
REQ-026 SHALL suppress exceptions while EXL=1 (no nesting); exc_code_m is ignored.

Reset
REQ-027 SHALL, while reset_n=0, clear SR, Cause and EPC to 0 immediately; epc=0, e_jump follows eret_m, and int_req=0 unless exc_code_m!=0.
REQ-028 SHALL let reset mid-HANDLER return to RUN, discarding EPC.

Configuration
REQ-029 SHALL, with CP0_BADVADDR_EN defined, add input badvaddr_m[31:0] and BadVAddr(8), latched on int_req when ExcCode is 4 or 5, reset 0, read-only.
REQ-030 SHALL, without CP0_BADVADDR_EN, omit both the port and the register; address 8 reads 0.

Structure
REQ-031 SHALL place register addresses, ExcCode constants, PRId value and handler address 32'h0000_4180 in shared package cp0_pkg.
REQ-032 SHALL isolate irq/exc detection and priority in sub-module cp0_irq_pri; registers and FSM stay in cp0_ctrl.

Verification
REQ-033 SHALL cover: SR=32'h0000_0401, hw_int=6'b000001, pc_m=32'h0000_3010 -> int_req=1 same cycle; next cycle EPC=32'h0000_3010, ExcCode=0, EXL=1.
REQ-034 SHALL cover: exc_code_m=10, bd_m=1, pc_m=32'h0000_3024 -> EPC=32'h0000_3020, Cause.BD=1, ExcCode=10.
REQ-035 SHALL cover: EXL=1 then exc_code_m=12 -> int_req=0 and EPC unchanged.
REQ-036 SHALL cover: eret_m=1 in HANDLER -> e_jump=1, epc=EPC; next cycle EXL=0.
REQ-037 SHALL cover: eret_m and irq in the same cycle -> int_req=1, e_jump=0, EXL stays 1.
REQ-038 SHALL cover: mtc0 to Cause with wdata=32'hFFFF_FFFF -> Cause unchanged; mtc0 EPC=32'h0000_3007 -> EPC=32'h0000_3004.
